turn_signal_seq: RTL and testbench

Parametrised sequential turn-signal lamp controller, the successor of the fixed three-lamp left/right sequencer. It drives N_LAMPS lamps per side with a thermometer sweep and adds hazard flashing, brake override and a runtime step-rate prescaler. It sits between the driver-control inputs (stalk left/right, hazard switch, brake pedal) and the lamp driver outputs. All outputs are registered.

---
 rtl/turn_signal_pkg.sv | 21 ++
 rtl/step_prescaler.sv | 39 +++
 rtl/turn_signal_seq.sv | 153 +++++++++++++++
 tb/tb_turn_signal_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the sequential turn-signal controller.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  // Thermometer pattern with bits [step-1:0] set, clipped to n lamps (n <= 32).
  function automatic logic [31:0] therm(input int step, input int n);
    logic [31:0] t;
    t = 32'd0;
    for (int i = 0; i < 32; i++) begin
      t[i] = (i < step) && (i < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: ticks when the count reaches div, restarts on clear.
module step_prescaler #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // A >= compare keeps the counter from running past a freshly lowered div.
  assign tick = (cnt_q >= div);

  // Next count: clear wins over tick, tick wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (tick) begin
      cnt_d = {DIV_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal lamp controller with hazard and step-rate prescaler.
// Optional brake override is compiled in with `define TURN_SIGNAL_BRAKE_EN.
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int N_LAMPS = 3,
  parameter int DIV_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               left,
  input  logic               right,
  input  logic               hazard,
  input  logic               brake,
  input  logic [DIV_W-1:0]   div,
  output logic [N_LAMPS-1:0] lamp_l,
  output logic [N_LAMPS-1:0] lamp_r,
  output logic [1:0]         mode
);

  localparam int STEP_W = $clog2(N_LAMPS + 1);

  mode_e               req_s;
  mode_e               mode_q;
  mode_e               mode_d;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   step_d;
  logic                tick_s;
  logic                clear_s;
  logic                brake_now_s;
  logic [N_LAMPS-1:0]  pat_s;
  logic [N_LAMPS-1:0]  lamp_l_q;
  logic [N_LAMPS-1:0]  lamp_l_d;
  logic [N_LAMPS-1:0]  lamp_r_q;
  logic [N_LAMPS-1:0]  lamp_r_d;

`ifdef TURN_SIGNAL_BRAKE_EN
  logic brake_q;
  logic brake_d;

  assign brake_d = brake;
  // Lamps are registered from next state, so brake_d lands with brake_q.
  assign brake_now_s = brake_d;

  // Brake sample register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brake_q <= 1'b0;
    end else begin
      brake_q <= brake_d;
    end
  end
`else
  logic unused_brake_s;

  assign unused_brake_s = brake;
  assign brake_now_s    = 1'b0;
`endif

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_s),
    .div     (div),
    .tick    (tick_s)
  );

  // Requested mode; both stalks at once count as hazard.
  always_comb begin
    req_s = MODE_IDLE;
    if (hazard || (left && right)) begin
      req_s = MODE_HAZARD;
    end else if (left) begin
      req_s = MODE_LEFT;
    end else if (right) begin
      req_s = MODE_RIGHT;
    end else begin
      req_s = MODE_IDLE;
    end
  end

  assign clear_s = (req_s != mode_q);

  // FSM next state and step counter.
  always_comb begin
    mode_d = req_s;
    step_d = step_q;
    if (clear_s) begin
      step_d = (req_s == MODE_IDLE) ? {STEP_W{1'b0}} : STEP_W'(1);
    end else if (tick_s) begin
      case (mode_q)
        MODE_LEFT, MODE_RIGHT: begin
          step_d = (step_q >= STEP_W'(N_LAMPS)) ? {STEP_W{1'b0}}
                                                : step_q + STEP_W'(1);
        end
        MODE_HAZARD: begin
          step_d = (step_q == {STEP_W{1'b0}}) ? STEP_W'(1) : {STEP_W{1'b0}};
        end
        default: begin
          step_d = {STEP_W{1'b0}};
        end
      endcase
    end else begin
      step_d = step_q;
    end
  end

  assign pat_s = N_LAMPS'(therm(int'(step_d), N_LAMPS));

  // Lamp patterns derived from the next state so they register with it.
  always_comb begin
    lamp_l_d = {N_LAMPS{1'b0}};
    lamp_r_d = {N_LAMPS{1'b0}};
    case (mode_d)
      MODE_LEFT: begin
        lamp_l_d = pat_s;
        lamp_r_d = brake_now_s ? {N_LAMPS{1'b1}} : {N_LAMPS{1'b0}};
      end
      MODE_RIGHT: begin
        lamp_l_d = brake_now_s ? {N_LAMPS{1'b1}} : {N_LAMPS{1'b0}};
        lamp_r_d = pat_s;
      end
      MODE_HAZARD: begin
        lamp_l_d = (step_d != {STEP_W{1'b0}}) ? {N_LAMPS{1'b1}} : {N_LAMPS{1'b0}};
        lamp_r_d = lamp_l_d;
      end
      default: begin
        lamp_l_d = brake_now_s ? {N_LAMPS{1'b1}} : {N_LAMPS{1'b0}};
        lamp_r_d = lamp_l_d;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_IDLE;
      step_q   <= {STEP_W{1'b0}};
      lamp_l_q <= {N_LAMPS{1'b0}};
      lamp_r_q <= {N_LAMPS{1'b0}};
    end else begin
      mode_q   <= mode_d;
      step_q   <= step_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
    end
  end

  assign lamp_l = lamp_l_q;
  assign lamp_r = lamp_r_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Scoreboard bench for turn_signal_seq: an N_LAMPS=3 and an N_LAMPS=4 instance.
module tb_turn_signal_seq;

`ifdef TURN_SIGNAL_BRAKE_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       l3, r3, h3, b3;
  logic [3:0] div3;
  logic [2:0] ll3, lr3;
  logic [1:0] m3;
  logic       l4, r4, h4, b4;
  logic [3:0] div4;
  logic [3:0] ll4, lr4;
  logic [1:0] m4;

  turn_signal_seq #(.N_LAMPS(3), .DIV_W(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .left(l3), .right(r3), .hazard(h3),
    .brake(b3), .div(div3), .lamp_l(ll3), .lamp_r(lr3), .mode(m3)
  );

  turn_signal_seq #(.N_LAMPS(4), .DIV_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .left(l4), .right(r4), .hazard(h4),
    .brake(b4), .div(div4), .lamp_l(ll4), .lamp_r(lr4), .mode(m4)
  );

  typedef struct {
    bit         sel;
    int         id;
    logic [3:0] ll;
    logic [3:0] lr;
    logic [1:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d got %b want %b", name, id, act, req);
    end
  endtask

  // Queue the response expected after the next edge, then move to the next negedge.
  task automatic push(input bit sel, input logic [3:0] ll, input logic [3:0] lr, input logic [1:0] m);
    exp_t e;
    e.sel = sel; e.id = vec_id; e.ll = ll; e.lr = lr; e.m = m;
    vec_id++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every clock edge the DUT presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
          chk("lamp_l3", e.id, {1'b0, ll3}, e.ll);
          chk("lamp_r3", e.id, {1'b0, lr3}, e.lr);
          chk("mode3",   e.id, {2'b00, m3}, {2'b00, e.m});
        end else begin
          chk("lamp_l4", e.id, ll4, e.ll);
          chk("lamp_r4", e.id, lr4, e.lr);
          chk("mode4",   e.id, {2'b00, m4}, {2'b00, e.m});
        end
      end
    end
  end

  logic [3:0] seq3 [5];
  logic [3:0] seq4 [6];
  logic [3:0] bside;

  initial begin
    seq3 = '{4'b0001, 4'b0011, 4'b0111, 4'b0000, 4'b0001};
    seq4 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
    bside = BRK_EN ? 4'b0111 : 4'b0000;

    reset_n = 1'b0;
    {l3, r3, h3, b3} = 4'b0000; div3 = 4'd1;
    {l4, r4, h4, b4} = 4'b0000; div4 = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_lamp_l3", -1, {1'b0, ll3}, 4'b0000);
    chk("rst_lamp_r3", -1, {1'b0, lr3}, 4'b0000);
    chk("rst_mode3",   -1, {2'b00, m3}, 4'b0000);
    chk("rst_lamp_l4", -1, ll4, 4'b0000);
    reset_n = 1'b1;
    push(1'b0, 4'b0000, 4'b0000, 2'd0);

    // Left sweep, div=1: each step held two cycles.
    l3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, seq3[i], 4'b0000, 2'd1);
      push(1'b0, seq3[i], 4'b0000, 2'd1);
    end
    l3 = 1'b0;
    push(1'b0, 4'b0000, 4'b0000, 2'd0);

    // Both stalks: hazard flash, brake ignored.
    l3 = 1'b1; r3 = 1'b1; b3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 4'b0111, 4'b0111, 2'd3);
      push(1'b0, 4'b0111, 4'b0111, 2'd3);
      push(1'b0, 4'b0000, 4'b0000, 2'd3);
      push(1'b0, 4'b0000, 4'b0000, 2'd3);
    end
    l3 = 1'b0; r3 = 1'b0; b3 = 1'b0;
    push(1'b0, 4'b0000, 4'b0000, 2'd0);

    // Right sweep with brake: left side lit only when brake is built in.
    r3 = 1'b1; b3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, bside, seq3[i], 2'd2);
      push(1'b0, bside, seq3[i], 2'd2);
    end
    r3 = 1'b0;
    push(1'b0, bside, bside, 2'd0);
    push(1'b0, bside, bside, 2'd0);
    b3 = 1'b0;
    push(1'b0, 4'b0000, 4'b0000, 2'd0);

    // Left to right switch while lamp_l=011: prescaler restarts.
    l3 = 1'b1;
    push(1'b0, 4'b0001, 4'b0000, 2'd1);
    push(1'b0, 4'b0001, 4'b0000, 2'd1);
    push(1'b0, 4'b0011, 4'b0000, 2'd1);
    l3 = 1'b0; r3 = 1'b1;
    push(1'b0, 4'b0000, 4'b0001, 2'd2);
    push(1'b0, 4'b0000, 4'b0001, 2'd2);
    push(1'b0, 4'b0000, 4'b0011, 2'd2);
    r3 = 1'b0;
    push(1'b0, 4'b0000, 4'b0000, 2'd0);

    // N_LAMPS=4, div=0: new step every cycle, 5-cycle period.
    l4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(1'b1, seq4[i], 4'b0000, 2'd1);
    end
    l4 = 1'b0;
    push(1'b1, 4'b0000, 4'b0000, 2'd0);

    // Asynchronous reset mid-hazard, then left sequence restarts cleanly.
    h3 = 1'b1;
    push(1'b0, 4'b0111, 4'b0111, 2'd3);
    reset_n = 1'b0;
    #1;
    chk("async_lamp_l3", -2, {1'b0, ll3}, 4'b0000);
    chk("async_lamp_r3", -2, {1'b0, lr3}, 4'b0000);
    chk("async_mode3",   -2, {2'b00, m3}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1; h3 = 1'b0; l3 = 1'b1;
    push(1'b0, 4'b0001, 4'b0000, 2'd1);
    push(1'b0, 4'b0001, 4'b0000, 2'd1);
    push(1'b0, 4'b0011, 4'b0000, 2'd1);
    l3 = 1'b0;
    push(1'b0, 4'b0000, 4'b0000, 2'd0);

    @(negedge clk);
    chk("queue_drained", -3, 4'(exp_q.size()), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
